// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32IM pipeline: ALU opcodes, forwarding selects and
// the multiply/divide FSM states.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SRL    = 5'd3,
    ALU_SRA    = 5'd4,
    ALU_SLT    = 5'd5,
    ALU_SLTU   = 5'd6,
    ALU_XOR    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic is_mop(input logic [4:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider working on operand magnitudes,
// with sign fix-up and RISC-V divide special cases applied when the result is presented.
module muldiv_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [4:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  input  logic            i_accept,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CW = $clog2(MD_CYCLES);

  md_state_t         r_state, w_state_nxt;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic [4:0]        r_op;
  logic [2*XLEN-1:0] r_acc, w_acc_step;
  logic [XLEN-1:0]   r_b, r_a;
  logic              r_neg_lo, r_neg_rem, r_div0, r_ovf;

  logic              w_launch, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [XLEN:0]     w_mul_sum, w_div_sh, w_div_diff;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem;

  assign w_launch   = (r_state == MD_IDLE) && i_start && !i_flush;
  assign w_a_signed = (i_op == ALU_MULH) || (i_op == ALU_MULHSU) || (i_op == ALU_DIV) ||
                      (i_op == ALU_REM);
  assign w_b_signed = (i_op == ALU_MULH) || (i_op == ALU_DIV) || (i_op == ALU_REM);
  assign w_a_neg    = w_a_signed && i_a[XLEN-1];
  assign w_b_neg    = w_b_signed && i_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? -i_a : i_a;
  assign w_b_mag    = w_b_neg ? -i_b : i_b;

  // Multiplier and dividend both start in the low half; the high half accumulates.
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_div_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};

  always_comb begin
    if (!r_op[2]) begin
      w_acc_step = {w_mul_sum, r_acc[XLEN-1:1]};
    end else if (w_div_diff[XLEN]) begin
      w_acc_step = {w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end else begin
      w_acc_step = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    unique case (r_state)
      MD_IDLE: begin
        if (w_launch) begin
          w_state_nxt = MD_BUSY;
          w_count_nxt = '0;
        end
      end
      MD_BUSY: begin
        if (r_count == CW'(MD_CYCLES - 1)) begin
          w_state_nxt = MD_DONE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      MD_DONE: begin
        if (i_accept) w_state_nxt = MD_IDLE;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
    if (i_flush) begin
      w_state_nxt = MD_IDLE;
      w_count_nxt = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= MD_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op      <= '0;
      r_acc     <= '0;
      r_b       <= '0;
      r_a       <= '0;
      r_neg_lo  <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_launch) begin
      r_op      <= i_op;
      r_acc     <= {{XLEN{1'b0}}, w_a_mag};
      r_b       <= w_b_mag;
      r_a       <= i_a;
      r_neg_lo  <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_div0    <= (i_b == '0);
      r_ovf     <= w_b_signed && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);
    end else if (r_state == MD_BUSY) begin
      r_acc <= w_acc_step;
    end
  end

  assign w_prod = r_neg_lo ? -r_acc : r_acc;
  assign w_quo  = r_neg_lo ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_neg_rem ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    o_result = '0;
    case (r_op)
      ALU_MUL:                         o_result = w_prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: o_result = w_prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU: begin
        if (r_div0)     o_result = '1;
        else if (r_ovf) o_result = {1'b1, {(XLEN-1){1'b0}}};
        else            o_result = w_quo;
      end
      ALU_REM, ALU_REMU: begin
        if (r_div0)     o_result = r_a;
        else if (r_ovf) o_result = '0;
        else            o_result = w_rem;
      end
      default:                         o_result = '0;
    endcase
  end

  assign o_busy = (r_state == MD_BUSY);
  assign o_done = (r_state == MD_DONE);

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, single-cycle ALU, multi-cycle multiply/divide and the
// EX/MEM pipeline register.
module execute_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MD_CYCLES = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_idex_valid,
  input  logic [4:0]      i_idex_rd,
  input  logic [XLEN-1:0] i_idex_imm,
  input  logic [XLEN-1:0] i_idex_read_data1,
  input  logic [XLEN-1:0] i_idex_read_data2,
  input  logic [4:0]      i_idex_alu_op,
  input  logic            i_idex_alu_src,
  input  logic            i_idex_wb,
  input  logic            i_idex_mem_read,
  input  logic            i_idex_mem_write,
  input  logic [1:0]      i_fwd_a_sel,
  input  logic [1:0]      i_fwd_b_sel,
  input  logic [XLEN-1:0] i_exmem_fwd_data,
  input  logic [XLEN-1:0] i_memwb_fwd_data,
  input  logic            i_flush,
  input  logic            i_mem_stall,
  output logic            o_stall_req,
  output logic            o_exmem_valid,
  output logic [XLEN-1:0] o_exmem_alu_result,
  output logic [XLEN-1:0] o_exmem_store_data,
  output logic [4:0]      o_exmem_rd,
  output logic            o_exmem_wb,
  output logic            o_exmem_mem_read,
  output logic            o_exmem_mem_write
);

  logic [XLEN-1:0] w_op_a, w_rs2, w_op_b, w_alu_result, w_md_result;
  logic [4:0]      w_shamt;
  logic            w_is_mop, w_md_busy, w_md_done, w_launch;

  always_comb begin
    case (i_fwd_a_sel)
      FWD_EXMEM: w_op_a = i_exmem_fwd_data;
      FWD_MEMWB: w_op_a = i_memwb_fwd_data;
      default:   w_op_a = i_idex_read_data1;
    endcase
    case (i_fwd_b_sel)
      FWD_EXMEM: w_rs2 = i_exmem_fwd_data;
      FWD_MEMWB: w_rs2 = i_memwb_fwd_data;
      default:   w_rs2 = i_idex_read_data2;
    endcase
  end

  assign w_op_b  = i_idex_alu_src ? i_idex_imm : w_rs2;
  assign w_shamt = w_op_b[4:0];

  always_comb begin
    w_alu_result = '0;
    case (i_idex_alu_op)
      ALU_ADD:   w_alu_result = w_op_a + w_op_b;
      ALU_SUB:   w_alu_result = w_op_a - w_op_b;
      ALU_SLL:   w_alu_result = w_op_a << w_shamt;
      ALU_SRL:   w_alu_result = w_op_a >> w_shamt;
      ALU_SRA:   w_alu_result = $unsigned($signed(w_op_a) >>> w_shamt);
      ALU_SLT:   w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_op_a) < $signed(w_op_b)};
      ALU_SLTU:  w_alu_result = {{(XLEN-1){1'b0}}, w_op_a < w_op_b};
      ALU_XOR:   w_alu_result = w_op_a ^ w_op_b;
      ALU_OR:    w_alu_result = w_op_a | w_op_b;
      ALU_AND:   w_alu_result = w_op_a & w_op_b;
      ALU_PASSB: w_alu_result = w_op_b;
      default:   w_alu_result = '0;
    endcase
  end

  assign w_is_mop = is_mop(i_idex_alu_op);
  assign w_launch = i_idex_valid && w_is_mop && !w_md_busy && !w_md_done && !i_flush;

  muldiv_unit #(
    .XLEN      (XLEN),
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_launch),
    .i_op     (i_idex_alu_op),
    .i_a      (w_op_a),
    .i_b      (w_op_b),
    .i_flush  (i_flush),
    .i_accept (!i_mem_stall),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  assign o_stall_req = !i_rst && (i_mem_stall || w_md_busy || w_launch);

  // An M op only reaches EX/MEM from DONE; before that the stage emits bubbles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_exmem_valid      <= 1'b0;
      o_exmem_alu_result <= '0;
      o_exmem_store_data <= '0;
      o_exmem_rd         <= '0;
      o_exmem_wb         <= 1'b0;
      o_exmem_mem_read   <= 1'b0;
      o_exmem_mem_write  <= 1'b0;
    end else if (!i_mem_stall) begin
      if (i_flush || !i_idex_valid || (w_is_mop && !w_md_done)) begin
        o_exmem_valid      <= 1'b0;
        o_exmem_alu_result <= '0;
        o_exmem_store_data <= '0;
        o_exmem_rd         <= '0;
        o_exmem_wb         <= 1'b0;
        o_exmem_mem_read   <= 1'b0;
        o_exmem_mem_write  <= 1'b0;
      end else begin
        o_exmem_valid      <= 1'b1;
        o_exmem_alu_result <= w_is_mop ? w_md_result : w_alu_result;
        o_exmem_store_data <= w_rs2;
        o_exmem_rd         <= i_idex_rd;
        o_exmem_wb         <= i_idex_wb;
        o_exmem_mem_read   <= i_idex_mem_read;
        o_exmem_mem_write  <= i_idex_mem_write;
      end
    end
  end

endmodule
